// File: rtl/load_store_unit.sv
// load_store_unit: word-only memory front end with sub-word RMW stores and extended, registered loads
module load_store_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  output logic                  mem_MemWrite_o,
  output logic                  mem_MemRead_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  load_valid_o,
  output logic                  misaligned_o
);
  typedef enum logic {IDLE, RMW_WR} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] rmw_addr, rmw_data, rmw_addr_nx, rmw_data_nx, merged, lane, ext;
  logic is_store, is_load, illegal, misal, bad, sub_store, load_ok;
  // classify the request: a store wins over a load, illegal or misaligned accesses are suppressed
  always_comb begin
    is_store  = MemWrite_i;
    is_load   = MemRead_i & ~MemWrite_i;
    illegal   = (funct3_i == 3'b011) | (funct3_i[2:1] == 2'b11) | (is_store & funct3_i[2]);
    misal     = ((funct3_i[1:0] == 2'b01) & addr_i[0]) | ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
    bad       = (is_store | is_load) & (illegal | misal);
    sub_store = is_store & ~bad & (funct3_i[1:0] != 2'b10);
    load_ok   = (state == IDLE) & is_load & ~bad;
  end
  // merge the sub-word store into the word read back this cycle
  always_comb begin
    merged = mem_rd_data_i;
    if (funct3_i[0]) merged[{addr_i[1], 4'b0000} +: 16] = store_data_i[15:0];
    else merged[{addr_i[1:0], 3'b000} +: 8] = store_data_i[7:0];
  end
  // select the addressed lane and extend it to a full word
  always_comb begin
    lane = mem_rd_data_i >> {addr_i[1:0], 3'b000};
    ext  = (funct3_i[1:0] == 2'b00) ? {{24{~funct3_i[2] & lane[7]}}, lane[7:0]} :
           (funct3_i[1:0] == 2'b01) ? {{16{~funct3_i[2] & lane[15]}}, lane[15:0]} : lane;
  end
  // next-state and memory-side strobes
  always_comb begin
    state_nx       = state;
    rmw_addr_nx    = rmw_addr;
    rmw_data_nx    = rmw_data;
    mem_addr_o     = addr_i;
    mem_wr_data_o  = store_data_i;
    mem_MemWrite_o = 1'b0;
    mem_MemRead_o  = 1'b0;
    stall_o        = 1'b0;
    if (state == RMW_WR) begin
      mem_addr_o     = rmw_addr;
      mem_wr_data_o  = rmw_data;
      mem_MemWrite_o = 1'b1;
      state_nx       = IDLE;
    end else if (sub_store) begin
      mem_MemRead_o = 1'b1;
      stall_o       = 1'b1;
      rmw_addr_nx   = {addr_i[DATA_WIDTH-1:2], 2'b00};
      rmw_data_nx   = merged;
      state_nx      = RMW_WR;
    end else if (~bad) begin
      mem_MemWrite_o = is_store;
      mem_MemRead_o  = is_load;
    end
  end
  // state and captured read-modify-write word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rmw_addr <= '0;
      rmw_data <= '0;
    end else begin
      state    <= state_nx;
      rmw_addr <= rmw_addr_nx;
      rmw_data <= rmw_data_nx;
    end
  end
  // registered load result and one-cycle status pulses toward WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_data_o  <= '0;
      load_valid_o <= 1'b0;
      misaligned_o <= 1'b0;
    end else begin
      load_valid_o <= load_ok;
      misaligned_o <= (state == IDLE) & bad;
      if (load_ok) load_data_o <= ext;
    end
  end
endmodule
